// File: rtl/simd_shift_pkg.sv
// Shared types and constants for the SIMD shift sequencer.
// Lane-mode codes and FSM state encoding.
package simd_shift_pkg;

    localparam logic [1:0] MODE_8    = 2'b00;
    localparam logic [1:0] MODE_4    = 2'b01;
    localparam logic [1:0] MODE_2    = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/simd_shift_step.sv
// Combinational 1-bit lane-aware logical shifter.
// Bits that would cross a lane boundary are masked to zero.
module simd_shift_step
    import simd_shift_pkg::*;
(
    input  logic [7:0] data,
    input  logic [1:0] mode,
    input  logic       left,
    output logic [7:0] result
);

    logic [7:0] raw;
    logic [7:0] mask;

    // Whole-byte shift, then clear the bit entering each lane's edge
    always_comb begin
        raw  = left ? {data[6:0], 1'b0} : {1'b0, data[7:1]};
        mask = 8'hFF;
        unique case (mode)
            MODE_4:  mask = left ? 8'hEE : 8'h77;
            MODE_2:  mask = left ? 8'hAA : 8'h55;
            default: mask = 8'hFF;
        endcase
        result = raw & mask;
    end

endmodule

// File: rtl/simd_shift_seq.sv
// Multi-bit shift sequencer: one lane-aware 1-bit step per cycle,
// result held under a valid/ready handshake.
module simd_shift_seq
    import simd_shift_pkg::*;
#(
    parameter int AMT_W      = 3,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_left,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_err,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       data_q;
    logic [AMT_W-1:0] cnt_q;
    logic [1:0]       mode_q;
    logic             left_q;
    logic [7:0]       step_data;
    logic             last_step;

    simd_shift_step u_step (
        .data   (data_q),
        .mode   (mode_q),
        .left   (left_q),
        .result (step_data)
    );

    assign last_step = (cnt_q == AMT_W'(1))
                     || ((EARLY_EXIT != 0) && (step_data == 8'h00));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (in_amt == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last_step) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Working registers: capture in IDLE, step in SHIFT, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
            left_q <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            data_q <= in_data;
            cnt_q  <= in_amt;
            mode_q <= in_mode;
            left_q <= in_left;
        end else if (state == ST_SHIFT) begin
            data_q <= step_data;
            cnt_q  <= cnt_q - AMT_W'(1);
        end
    end

    assign out_data = data_q;
    assign out_err  = (state == ST_DONE) && (mode_q == MODE_RSVD);

endmodule

// File: tb/tb_simd_shift_seq.sv
// Directed self-checking bench for simd_shift_seq.
// Runs one normal and one early-exit instance side by side.
module tb_simd_shift_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_left;
    logic [1:0] in_mode;
    logic       out_ready;

    logic       in_ready, out_valid, out_err, busy;
    logic [7:0] out_data;
    logic       ee_in_ready, ee_out_valid, ee_out_err, ee_busy;
    logic [7:0] ee_out_data;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    simd_shift_seq #(.AMT_W(3), .EARLY_EXIT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt),
        .in_left(in_left), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .busy(busy)
    );

    simd_shift_seq #(.AMT_W(3), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ee_in_ready),
        .in_data(in_data), .in_amt(in_amt),
        .in_left(in_left), .in_mode(in_mode),
        .out_valid(ee_out_valid), .out_ready(out_ready),
        .out_data(ee_out_data), .out_err(ee_out_err), .busy(ee_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic [7:0] d,
                          input logic [2:0] a, input logic l,
                          input logic [1:0] m, input logic [7:0] ed,
                          input logic ee);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_amt = a;
        in_left = l; in_mode = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_data = ~d; in_amt = 3'd1;
        in_left = ~l; in_mode = 2'b00;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(a));
        chk({tag, "_data"}, 32'(out_data), 32'(ed));
        chk({tag, "_err"}, 32'(out_err), 32'(ee));
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
        chk({tag, "_vld0"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat0, lat1, rises;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0;
        in_left = 1'b0; in_mode = '0; out_ready = 1'b1;
        #12;
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req("m8_l3",  8'h96, 3'd3, 1'b1, 2'b00, 8'hB0, 1'b0);
        do_req("m4_r1",  8'hF8, 3'd1, 1'b0, 2'b01, 8'h74, 1'b0);
        do_req("m4_l2",  8'h39, 3'd2, 1'b1, 2'b01, 8'hC4, 1'b0);
        do_req("m2_l1",  8'hE4, 3'd1, 1'b1, 2'b10, 8'h88, 1'b0);
        do_req("m2_r1",  8'hE4, 3'd1, 1'b0, 2'b10, 8'h50, 1'b0);
        do_req("rsv_r4", 8'hF0, 3'd4, 1'b0, 2'b11, 8'h0F, 1'b1);

        // amount 0 with consumer stalled
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A; in_amt = 3'd0;
        in_left = 1'b1; in_mode = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_data = 8'(i * 37);
            in_valid = 1'b1;
            chk("a0_vld", 32'(out_valid), 32'd1);
            chk("a0_data", 32'(out_data), 32'h5A);
            chk("a0_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("a0_idle", 32'(in_ready), 32'd1);
        chk("a0_vld0", 32'(out_valid), 32'd0);

        // all-zero result: early exit vs full count
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd7;
        in_left = 1'b1; in_mode = 2'b10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat0 = -1; lat1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && lat0 < 0) begin
                lat0 = i;
                chk("ee0_data", 32'(out_data), 32'h00);
            end
            if (ee_out_valid && lat1 < 0) begin
                lat1 = i;
                chk("ee1_data", 32'(ee_out_data), 32'h00);
            end
            if (lat0 >= 0 && lat1 >= 0) break;
        end
        chk("ee0_lat", 32'(lat0), 32'd7);
        chk("ee1_lat", 32'(lat1), 32'd2);
        @(negedge clk);
        @(negedge clk);

        // async reset mid-shift
        in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd5;
        in_left = 1'b1; in_mode = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("ar_busy1", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_rdy", 32'(in_ready), 32'd1);
        chk("ar_vld", 32'(out_valid), 32'd0);
        chk("ar_data", 32'(out_data), 32'd0);
        chk("ar_err", 32'(out_err), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        chk("ar_novld", 32'(rises), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/simd_shift_seq.md
Name: simd_shift_seq

Overview:
- Multi-bit shift sequencer for the 8-bit SIMD datapath.
- Accepts one shift request: data, amount 0..7, direction and lane mode.
- Produces the result by applying a lane-aware 1-bit shift step once per cycle, then holds the result under a valid/ready handshake.
- Sits between the instruction/operand path and the writeback path; owns the 1-bit shift step.

Parameters:
- AMT_W, 3, width of the shift amount; maximum amount is 2^AMT_W-1.
- EARLY_EXIT, 0, when 1, go to DONE as soon as the working data is all zeros.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  8  operand.
- in_amt  input  AMT_W  shift amount.
- in_left  input  1  1 = logical left, 0 = logical right.
- in_mode  input  2  00 = 1x8-bit, 01 = 2x4-bit, 10 = 4x2-bit, 11 = reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  8  shifted result.
- out_err  output  1  reserved mode was used; qualified by out_valid.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: async, active-low. State = IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, busy=0, all internal registers = 0.
- Lane rule: logical shift within each lane, zero filled. No bits cross lane boundaries. Amount >= lane width gives a zero lane.
- Mode 11: behaves as 1x8-bit and sets out_err=1.
- IDLE: in_ready=1. On in_valid at edge E0, capture data, amount, direction and mode into working registers; load cnt=in_amt.
  - If in_amt==0 -> DONE.
  - Otherwise -> SHIFT.
- SHIFT: in_ready=0. Each edge: data <= step(data); cnt <= cnt-1. On the edge where cnt==1, go to DONE.
  - With EARLY_EXIT=1: if step(data)==0, go to DONE on that edge regardless of cnt.
- DONE: out_valid=1, in_ready=0. out_data and out_err stay stable until out_ready. On out_valid & out_ready -> IDLE.
- Latency: out_valid is first high in the cycle after edge E0+N, where N = in_amt (N=0 gives the cycle after E0).
- Throughput: one request in flight. in_ready is not asserted in DONE, so no same-cycle accept on completion.
- Inputs are ignored outside IDLE. Captured operands are immune to input changes after E0.
- Reset asserted in any state aborts the operation immediately; the result is lost and no out_valid is produced.
- out_data is driven from the working register; it is only meaningful while out_valid=1.

Decomposition:
- Package simd_shift_pkg:
  - mode localparams MODE_8, MODE_4, MODE_2, MODE_RSVD.
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module simd_shift_step: combinational 1-bit lane-aware shifter.
  - Inputs: data[7:0], mode[1:0], left. Output: 8-bit result.
  - Mode 11 maps to 8-bit.
  - Instantiated once in simd_shift_seq.

Test Plan:
- Mode 00, left, amt 3, data 0x96 -> out_data 0xB0. out_valid first high the cycle after E0+3; out_err=0.
- Mode 01 cases:
  - right, amt 1, data 0xF8 -> 0x74.
  - left, amt 2, data 0x39 -> 0xC4.
- Mode 10 cases:
  - left, amt 1, data 0xE4 -> 0x88.
  - right, amt 1, data 0xE4 -> 0x50.
- amt 0, data 0x5A, out_ready held low 4 cycles:
  - out_valid the cycle after E0; out_data stays 0x5A; in_ready=0 throughout.
  - Returns to IDLE on the out_ready edge.
- Mode 10, left, amt 7, data 0xFF -> 0x00:
  - EARLY_EXIT=0: done after 7 shift edges.
  - EARLY_EXIT=1: done after 2 shift edges.
- Reset and error cases:
  - Mode 11, right, amt 4, data 0xF0 -> 0x0F with out_err=1.
  - rst_n pulsed low during SHIFT -> all outputs 0 and in_ready=1 immediately (asynchronous); no out_valid follows.
